// File: rtl/dice_game_param_if.sv
// Dice game bus: roll button in, game results and tallies out.
//   master : drives rb, observes results (testbench / host)
//   slave  : samples rb, drives results (dice_game_param)
//   rb                 roll button level; a rising edge is one request
//   win / lose         registered game outcome, held until restart
//   sum/count1/count2  last captured roll
//   point              point sum, 0 while no point is set
//   win_cnt/lose_cnt   saturating tallies since reset
interface dice_game_param_if #(
    parameter int FACES = 6,
    parameter int CNT_W = 8
);
    localparam int DW = $clog2(FACES + 1);
    localparam int SW = $clog2(2 * FACES + 1);

    logic             rb;
    logic             win;
    logic             lose;
    logic [SW-1:0]    sum;
    logic [DW-1:0]    count1;
    logic [DW-1:0]    count2;
    logic [SW-1:0]    point;
    logic [CNT_W-1:0] win_cnt;
    logic [CNT_W-1:0] lose_cnt;

    modport master (
        output rb,
        input  win, lose, sum, count1, count2, point, win_cnt, lose_cnt
    );

    modport slave (
        input  rb,
        output win, lose, sum, count1, count2, point, win_cnt, lose_cnt
    );
endinterface

// File: rtl/dice_game_param.sv
// Parametrised two-dice game controller.
// Two cascaded free-running counters act as the dice; a rising edge on rb
// captures them, the following cycle evaluates the roll against the
// first-roll or point rules. A rising edge after a finished game restarts
// it while keeping the win/lose tallies.
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    dice_game_param_if slave modport (rb in, results out)
module dice_game_param #(
    parameter int FACES   = 6,
    parameter int WIN1    = 12,
    parameter int LOSE1   = 2,
    parameter int LOSE_PT = 6,
    parameter int CNT_W   = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    dice_game_param_if.slave         bus
);
    localparam int DW = $clog2(FACES + 1);
    localparam int SW = $clog2(2 * FACES + 1);

    typedef enum logic [2:0] {
        S_FIRST, S_EVAL1, S_POINT, S_EVALP, S_WIN, S_LOSE
    } state_t;

    state_t           state_q, state_d;
    logic             rb_q;
    logic             rb_rise;
    logic [DW-1:0]    die1_q, die1_d, die2_q, die2_d;
    logic [DW-1:0]    count1_q, count1_d, count2_q, count2_d;
    logic [SW-1:0]    sum_q, sum_d, point_q, point_d;
    logic             win_q, win_d, lose_q, lose_d;
    logic [CNT_W-1:0] win_cnt_q, win_cnt_d, lose_cnt_q, lose_cnt_d;

    assign rb_rise = bus.rb & ~rb_q;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FIRST;
        else       state_q <= state_d;
    end

    // Next-state logic; sums compared as integers so out-of-range
    // parameters can never alias onto a narrow sum.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FIRST: if (rb_rise) state_d = S_EVAL1;
            S_EVAL1: begin
                if (int'(sum_q) == WIN1)       state_d = S_WIN;
                else if (int'(sum_q) == LOSE1) state_d = S_LOSE;
                else                           state_d = S_POINT;
            end
            S_POINT: if (rb_rise) state_d = S_EVALP;
            S_EVALP: begin
                // A point match wins even when the point equals LOSE_PT.
                if (sum_q == point_q)            state_d = S_WIN;
                else if (int'(sum_q) == LOSE_PT) state_d = S_LOSE;
                else                             state_d = S_POINT;
            end
            S_WIN, S_LOSE: if (rb_rise) state_d = S_FIRST;
            default: state_d = S_FIRST;
        endcase
    end

    // Output / datapath next-state logic
    always_comb begin
        // die2 steps only on the edge where die1 wraps back to 1
        die1_d     = (die1_q == DW'(FACES)) ? DW'(1) : die1_q + DW'(1);
        die2_d     = die2_q;
        if (die1_q == DW'(FACES))
            die2_d = (die2_q == DW'(FACES)) ? DW'(1) : die2_q + DW'(1);

        count1_d   = count1_q;
        count2_d   = count2_q;
        sum_d      = sum_q;
        point_d    = point_q;
        win_d      = win_q;
        lose_d     = lose_q;
        win_cnt_d  = win_cnt_q;
        lose_cnt_d = lose_cnt_q;

        // Capture uses the pre-increment die values
        if ((state_q == S_FIRST || state_q == S_POINT) && rb_rise) begin
            count1_d = die1_q;
            count2_d = die2_q;
            sum_d    = SW'(die1_q) + SW'(die2_q);
        end

        if (state_q == S_EVAL1 && state_d == S_POINT)
            point_d = sum_q;

        if (state_q != S_WIN && state_d == S_WIN) begin
            win_d     = 1'b1;
            win_cnt_d = (win_cnt_q == '1) ? win_cnt_q : win_cnt_q + CNT_W'(1);
        end
        if (state_q != S_LOSE && state_d == S_LOSE) begin
            lose_d     = 1'b1;
            lose_cnt_d = (lose_cnt_q == '1) ? lose_cnt_q : lose_cnt_q + CNT_W'(1);
        end

        // Restart clears the game but not the tallies; no roll is captured
        if ((state_q == S_WIN || state_q == S_LOSE) && rb_rise) begin
            win_d    = 1'b0;
            lose_d   = 1'b0;
            sum_d    = '0;
            count1_d = '0;
            count2_d = '0;
            point_d  = '0;
        end
    end

    // Datapath registers; rb_q resets high so a held button is not a roll
    always_ff @(posedge clk) begin
        if (reset) begin
            rb_q       <= 1'b1;
            die1_q     <= DW'(1);
            die2_q     <= DW'(1);
            count1_q   <= '0;
            count2_q   <= '0;
            sum_q      <= '0;
            point_q    <= '0;
            win_q      <= 1'b0;
            lose_q     <= 1'b0;
            win_cnt_q  <= '0;
            lose_cnt_q <= '0;
        end else begin
            rb_q       <= bus.rb;
            die1_q     <= die1_d;
            die2_q     <= die2_d;
            count1_q   <= count1_d;
            count2_q   <= count2_d;
            sum_q      <= sum_d;
            point_q    <= point_d;
            win_q      <= win_d;
            lose_q     <= lose_d;
            win_cnt_q  <= win_cnt_d;
            lose_cnt_q <= lose_cnt_d;
        end
    end

    assign bus.win      = win_q;
    assign bus.lose     = lose_q;
    assign bus.sum      = sum_q;
    assign bus.count1   = count1_q;
    assign bus.count2   = count2_q;
    assign bus.point    = point_q;
    assign bus.win_cnt  = win_cnt_q;
    assign bus.lose_cnt = lose_cnt_q;
endmodule

// File: tb/tb_dice_game_param.sv
module tb_dice_game_param;
    localparam int F  = 6;
    localparam int DW = $clog2(F + 1);
    localparam int SW = $clog2(2 * F + 1);
    localparam int HW = 2 + 2 * SW + 2 * DW;
    localparam int VW = 2 * HW + 16 + 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rb = 1'b0;
    int   nchk = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    // Two instances share stimulus; they differ only in tally width.
    dice_game_param_if #(.FACES(F), .CNT_W(8)) b1 ();
    dice_game_param_if #(.FACES(F), .CNT_W(2)) b2 ();
    assign b1.rb = rb;
    assign b2.rb = rb;

    dice_game_param #(.FACES(F), .WIN1(12), .LOSE1(2), .LOSE_PT(6), .CNT_W(8))
        dut1 (.clk(clk), .reset(reset), .bus(b1));
    dice_game_param #(.FACES(F), .WIN1(12), .LOSE1(2), .LOSE_PT(6), .CNT_W(2))
        dut2 (.clk(clk), .reset(reset), .bus(b2));

    logic [VW-1:0] obs;
    assign obs = {b1.win, b1.lose, b1.sum, b1.count1, b1.count2, b1.point,
                  b2.win, b2.lose, b2.sum, b2.count1, b2.count2, b2.point,
                  b1.win_cnt, b1.lose_cnt, b2.win_cnt, b2.lose_cnt};

    // Reference model: game-level view (edge index, pending roll, outcome)
    int mn, msum, mc1, mc2, mpt, mwc, mlc;
    bit mwin, mlose, mrbp, mpend, mfirst, mover;

    task automatic model_step(input logic r, input logic rs);
        int d1, d2;
        bit rise;
        if (rs) begin
            mn = 0; msum = 0; mc1 = 0; mc2 = 0; mpt = 0; mwc = 0; mlc = 0;
            mwin = 0; mlose = 0; mrbp = 1; mpend = 0; mover = 0;
            return;
        end
        rise = r && !mrbp;
        d1 = 1 + mn % F;
        d2 = 1 + (mn / F) % F;
        if (mpend) begin
            mpend = 0;
            if (mfirst) begin
                if (msum == 12)     begin mwin = 1;  mwc++; mover = 1; end
                else if (msum == 2) begin mlose = 1; mlc++; mover = 1; end
                else mpt = msum;
            end else begin
                if (msum == mpt)    begin mwin = 1;  mwc++; mover = 1; end
                else if (msum == 6) begin mlose = 1; mlc++; mover = 1; end
            end
        end else if (mover) begin
            if (rise) begin
                mwin = 0; mlose = 0; msum = 0; mc1 = 0; mc2 = 0; mpt = 0;
                mover = 0;
            end
        end else if (rise) begin
            mc1 = d1; mc2 = d2; msum = d1 + d2;
            mpend = 1;
            mfirst = (mpt == 0);
        end
        mn++;
        mrbp = r;
    endtask

    function automatic logic [VW-1:0] exp_vec();
        logic [SW-1:0] s, p;
        logic [DW-1:0] a, b;
        logic [7:0] w8, l8;
        logic [1:0] w2, l2;
        s = SW'(msum); p = SW'(mpt); a = DW'(mc1); b = DW'(mc2);
        w8 = (mwc > 255) ? 8'd255 : 8'(mwc);
        l8 = (mlc > 255) ? 8'd255 : 8'(mlc);
        w2 = (mwc > 3) ? 2'd3 : 2'(mwc);
        l2 = (mlc > 3) ? 2'd3 : 2'(mlc);
        return {mwin, mlose, s, a, b, p, mwin, mlose, s, a, b, p, w8, l8, w2, l2};
    endfunction

    // One clock: inputs set away from the edge, model advanced, sample at negedge
    task automatic cyc(input logic r, input logic rs);
        rb = r;
        reset = rs;
        @(posedge clk);
        model_step(r, rs);
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) cyc(1'b1, 1'b1);
        nchk++;
        if (obs !== '0) begin
            nerr++;
            $display("FAIL reset_zero: got %h want 0", obs);
        end
        repeat (3) cyc(1'b1, 1'b0);
        nchk++;
        if (b1.sum !== '0 || obs !== exp_vec()) begin
            nerr++;
            $display("FAIL reset_held_rb: got %h want %h", obs, exp_vec());
        end
    endtask

    task automatic test_first_win();
        cyc(1'b0, 1'b1);
        repeat (35) cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        nchk++;
        if ({b1.count1, b1.count2, b1.sum, b1.win} !== {3'd6, 3'd6, 4'd12, 1'b0}) begin
            nerr++;
            $display("FAIL first_win_capture: got %0d %0d %0d win=%0d want 6 6 12 0",
                     b1.count1, b1.count2, b1.sum, b1.win);
        end
        cyc(1'b0, 1'b0);
        nchk++;
        if ({b1.win, b1.lose, b1.win_cnt, b1.point} !== {1'b1, 1'b0, 8'd1, 4'd0}) begin
            nerr++;
            $display("FAIL first_win_result: got win=%0d lose=%0d wc=%0d pt=%0d want 1 0 1 0",
                     b1.win, b1.lose, b1.win_cnt, b1.point);
        end
        nchk++;
        if (obs !== exp_vec()) begin
            nerr++;
            $display("FAIL first_win_model: got %h want %h", obs, exp_vec());
        end
    endtask

    task automatic test_first_lose();
        cyc(1'b0, 1'b1);
        repeat (36) cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        nchk++;
        if ({b1.sum, b1.lose, b1.win, b1.lose_cnt} !== {4'd2, 1'b1, 1'b0, 8'd1}) begin
            nerr++;
            $display("FAIL first_lose: got sum=%0d lose=%0d win=%0d lc=%0d want 2 1 0 1",
                     b1.sum, b1.lose, b1.win, b1.lose_cnt);
        end
        cyc(1'b1, 1'b0);
        nchk++;
        if ({b1.win, b1.lose, b1.sum, b1.count1, b1.count2, b1.point, b1.lose_cnt}
            !== {2'b00, 4'd0, 3'd0, 3'd0, 4'd0, 8'd1}) begin
            nerr++;
            $display("FAIL restart_clear: got %h want lose_cnt=1 rest 0", obs);
        end
        cyc(1'b0, 1'b0);
        nchk++;
        if (b1.sum !== '0 || obs !== exp_vec()) begin
            nerr++;
            $display("FAIL restart_no_capture: got %h want %h", obs, exp_vec());
        end
    endtask

    task automatic test_point_win();
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0); cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        nchk++;
        if ({b1.point, b1.sum, b1.win, b1.lose} !== {4'd4, 4'd4, 2'b00}) begin
            nerr++;
            $display("FAIL point_set: got pt=%0d sum=%0d w=%0d l=%0d want 4 4 0 0",
                     b1.point, b1.sum, b1.win, b1.lose);
        end
        repeat (3) cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        nchk++;
        if ({b1.count1, b1.count2, b1.sum, b1.win, b1.point} !== {3'd2, 3'd2, 4'd4, 1'b1, 4'd4}) begin
            nerr++;
            $display("FAIL point_win: got %0d %0d sum=%0d win=%0d pt=%0d want 2 2 4 1 4",
                     b1.count1, b1.count2, b1.sum, b1.win, b1.point);
        end
    endtask

    task automatic test_point_lose();
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0); cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        nchk++;
        if ({b1.count1, b1.count2, b1.sum, b1.lose, b1.win} !== {3'd5, 3'd1, 4'd6, 1'b1, 1'b0}) begin
            nerr++;
            $display("FAIL point_lose: got %0d %0d sum=%0d lose=%0d win=%0d want 5 1 6 1 0",
                     b1.count1, b1.count2, b1.sum, b1.lose, b1.win);
        end
    endtask

    task automatic test_point_continue();
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0); cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0); cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        nchk++;
        if ({b1.sum, b1.point, b1.win, b1.lose} !== {4'd7, 4'd4, 2'b00}) begin
            nerr++;
            $display("FAIL point_continue: got sum=%0d pt=%0d w=%0d l=%0d want 7 4 0 0",
                     b1.sum, b1.point, b1.win, b1.lose);
        end
        repeat (10) cyc(1'b1, 1'b0);
        nchk++;
        if ({b1.count1, b1.count2, b1.win, b1.win_cnt} !== {3'd2, 3'd2, 1'b1, 8'd1}) begin
            nerr++;
            $display("FAIL held_rb_once: got %0d %0d win=%0d wc=%0d want 2 2 1 1",
                     b1.count1, b1.count2, b1.win, b1.win_cnt);
        end
    endtask

    task automatic test_saturate();
        cyc(1'b0, 1'b1);
        for (int g = 0; g < 4; g++) begin
            while (mn % 36 != 35) cyc(1'b0, 1'b0);
            cyc(1'b1, 1'b0);
            cyc(1'b0, 1'b0);
            if (g < 3) begin
                cyc(1'b1, 1'b0);
                cyc(1'b0, 1'b0);
            end
        end
        nchk++;
        if ({b1.win_cnt, b2.win_cnt, b2.win} !== {8'd4, 2'd3, 1'b1}) begin
            nerr++;
            $display("FAIL win_saturate: got wc8=%0d wc2=%0d win=%0d want 4 3 1",
                     b1.win_cnt, b2.win_cnt, b2.win);
        end
    endtask

    task automatic test_reset_mid();
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0); cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b1);
        nchk++;
        if (obs !== '0) begin
            nerr++;
            $display("FAIL reset_mid_point: got %h want 0", obs);
        end
        cyc(1'b0, 1'b0); cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        nchk++;
        if ({b1.count1, b1.count2} !== {3'd3, 3'd1}) begin
            nerr++;
            $display("FAIL dice_resume: got %0d %0d want 3 1", b1.count1, b1.count2);
        end
    endtask

    task automatic test_random();
        cyc(1'b0, 1'b1);
        for (int i = 0; i < 3000; i++) begin
            cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 299) == 0));
            nchk++;
            if (obs !== exp_vec()) begin
                nerr++;
                $display("FAIL random_cycle %0d: got %h want %h", i, obs, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_win();
        test_first_lose();
        test_point_win();
        test_point_lose();
        test_point_continue();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
